// File: rtl/stream_mon_pkg.sv
// -----------------------------------------------------------------------------
// stream_mon_pkg
// Shared types and default constants for the stream pattern monitor.
//   det_state_t  : detection FSM state (IDLE -> FILL -> RUN)
//   DEF_PAT_W    : default pattern length in bits
//   DEF_PATTERN  : default pattern, MSB is the oldest bit
//   DEF_WINDOW   : default number of qualified samples per report window
// -----------------------------------------------------------------------------
package stream_mon_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      RUN
   } det_state_t;

   localparam int                    DEF_PAT_W   = 4;
   localparam logic [DEF_PAT_W-1:0]  DEF_PATTERN = 4'b1011;
   localparam int                    DEF_WINDOW  = 16;

endpackage

// File: rtl/pattern_matcher.sv
// -----------------------------------------------------------------------------
// pattern_matcher
// Serial bit-pattern detector with overlapping matches. Holds the sample
// history, runs the IDLE/FILL/RUN detection FSM and drives the registered
// match pulse.
// Ports:
//   clk     in  : rising-edge clock
//   reset   in  : asynchronous, active-low reset
//   din     in  : serial data bit
//   din_en  in  : sample qualifier, din consumed only when 1
//   hit     out : combinational match of the sample being taken this cycle
//   match   out : registered one-cycle pulse, one cycle after the sample
// -----------------------------------------------------------------------------
module pattern_matcher
   import stream_mon_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   input  logic din_en,
   output logic hit,
   output logic match
);

   // fill_cnt_q counts samples taken while in FILL (1 .. PAT_W-1).
   localparam int               FILL_W    = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(PAT_W - 1);

   det_state_t        state_q;
   logic [FILL_W-1:0] fill_cnt_q;
   // Only the newest PAT_W-1 bits need storing: the oldest bit of the full
   // history falls off in the same shift that the comparison looks at.
   logic [PAT_W-2:0]  hist_q, hist_d;
   logic              match_q, match_d;
   logic [PAT_W-1:0]  hist_new;
   logic              armed;

   // NOTE: every signal written here gets a value on every path first, so
   // no latch can be inferred.
   always_comb begin
      hist_new = {hist_q, din};
      // The PAT_W-th sample after reset is the first that may complete a match.
      armed    = (state_q == RUN) || ((state_q == FILL) && (fill_cnt_q == LAST_FILL));
      hit      = din_en && armed && (hist_new == PATTERN);
      hist_d   = din_en ? hist_new[PAT_W-2:0] : hist_q;
      match_d  = hit;
   end

   // NOTE: state elements are updated only with non-blocking assignments so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         fill_cnt_q <= '0;
         hist_q     <= '0;
         match_q    <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         match_q <= match_d;
         if (din_en) begin
            case (state_q)
               IDLE: begin
                  state_q    <= FILL;
                  fill_cnt_q <= FILL_W'(1);
               end
               FILL: begin
                  if (fill_cnt_q == LAST_FILL) state_q <= RUN;
                  else                         fill_cnt_q <= fill_cnt_q + FILL_W'(1);
               end
               RUN:     state_q <= RUN;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign match = match_q;

endmodule

// File: rtl/stream_pattern_monitor.sv
// -----------------------------------------------------------------------------
// stream_pattern_monitor
// Counts pattern matches in the serial stream over fixed windows of qualified
// samples and offers each window count over a valid/ready handshake. A count
// that finds the report slot still occupied is dropped and flags overrun.
// Optional build macro STREAM_MON_RUNLEN_EN adds max_run, the longest run of
// consecutive 1s in the window, reported alongside rpt_count.
// Ports:
//   clk        in  : rising-edge clock
//   reset      in  : asynchronous, active-low reset
//   din        in  : serial data bit
//   din_en     in  : sample qualifier
//   match      out : registered one-cycle pulse per detected pattern
//   rpt_valid  out : window count available
//   rpt_ready  in  : downstream accepts the count
//   rpt_count  out : matches in the completed window
//   overrun    out : sticky, a window count was dropped
//   clear      in  : synchronous clear of overrun (a same-cycle set wins)
//   max_run    out : (STREAM_MON_RUNLEN_EN only) longest 1-run in the window
// -----------------------------------------------------------------------------
module stream_pattern_monitor
   import stream_mon_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
   parameter int               WINDOW  = DEF_WINDOW,
   parameter int               CNT_W   = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_en,
   output logic             match,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [CNT_W-1:0] rpt_count,
   output logic             overrun,
   input  logic             clear
`ifdef STREAM_MON_RUNLEN_EN
   ,
   output logic [CNT_W-1:0] max_run
`endif
);

   localparam int               SAMP_W   = $clog2(WINDOW);
   localparam logic [SAMP_W-1:0] SAMP_END = SAMP_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   logic              hit;
   logic [SAMP_W-1:0] samp_cnt_q,  samp_cnt_d;
   logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
   logic              rpt_valid_q, rpt_valid_d;
   logic [CNT_W-1:0]  rpt_count_q, rpt_count_d;
   logic              overrun_q,   overrun_d;
   logic [CNT_W-1:0]  final_cnt;
   logic              win_end, load;
`ifdef STREAM_MON_RUNLEN_EN
   logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0]  run_max_q, run_max_d;
   logic [CNT_W-1:0]  max_run_q, max_run_d;
   logic [CNT_W-1:0]  run_new, run_peak;
`endif

   pattern_matcher #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_matcher (
      .clk    (clk),
      .reset  (reset),
      .din    (din),
      .din_en (din_en),
      .hit    (hit),
      .match  (match)
   );

   always_comb begin
      win_end   = din_en && (samp_cnt_q == SAMP_END);
      // The match completed by the window's last sample belongs to that window.
      final_cnt = match_cnt_q;
      if (hit && (match_cnt_q != CNT_MAX)) final_cnt = match_cnt_q + CNT_W'(1);
      // A slot being drained this cycle is free for the new count.
      load      = win_end && (!rpt_valid_q || rpt_ready);

      samp_cnt_d  = samp_cnt_q;
      match_cnt_d = match_cnt_q;
      if (din_en) begin
         samp_cnt_d  = win_end ? '0 : samp_cnt_q + SAMP_W'(1);
         match_cnt_d = win_end ? '0 : final_cnt;
      end

      rpt_valid_d = rpt_valid_q && !rpt_ready;
      rpt_count_d = rpt_count_q;
      if (load) begin
         rpt_valid_d = 1'b1;
         rpt_count_d = final_cnt;
      end

      if (win_end && !load) overrun_d = 1'b1;
      else if (clear)       overrun_d = 1'b0;
      else                  overrun_d = overrun_q;

`ifdef STREAM_MON_RUNLEN_EN
      run_new   = '0;
      if (din) run_new = (run_cnt_q == CNT_MAX) ? CNT_MAX : run_cnt_q + CNT_W'(1);
      run_peak  = (run_new > run_max_q) ? run_new : run_max_q;
      run_cnt_d = run_cnt_q;
      run_max_d = run_max_q;
      if (din_en) begin
         // Runs never carry into the next window.
         run_cnt_d = win_end ? '0 : run_new;
         run_max_d = win_end ? '0 : run_peak;
      end
      max_run_d = load ? run_peak : max_run_q;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         samp_cnt_q  <= '0;
         match_cnt_q <= '0;
         rpt_valid_q <= 1'b0;
         rpt_count_q <= '0;
         overrun_q   <= 1'b0;
`ifdef STREAM_MON_RUNLEN_EN
         run_cnt_q   <= '0;
         run_max_q   <= '0;
         max_run_q   <= '0;
`endif
      end else begin
         samp_cnt_q  <= samp_cnt_d;
         match_cnt_q <= match_cnt_d;
         rpt_valid_q <= rpt_valid_d;
         rpt_count_q <= rpt_count_d;
         overrun_q   <= overrun_d;
`ifdef STREAM_MON_RUNLEN_EN
         run_cnt_q   <= run_cnt_d;
         run_max_q   <= run_max_d;
         max_run_q   <= max_run_d;
`endif
      end
   end

   assign rpt_valid = rpt_valid_q;
   assign rpt_count = rpt_count_q;
   assign overrun   = overrun_q;
`ifdef STREAM_MON_RUNLEN_EN
   assign max_run   = max_run_q;
`endif

endmodule

// File: doc/stream_pattern_monitor.md
# stream_pattern_monitor

Downstream consumer of the `behavioral_model` serial output `y`. The block samples the bit stream, detects a programmable bit pattern (overlapping matches allowed), and counts matches over fixed-length sample windows. It presents each window's count to a downstream reader over a valid/ready handshake and flags windows lost to backpressure.

## Interface
Parameters:
- `PAT_W`, 4: pattern length in bits, 2..8.
- `PATTERN`, 4'b1011: pattern to match. MSB is the oldest bit.
- `WINDOW`, 16: samples per report window. Must satisfy `WINDOW >= PAT_W`.
- `CNT_W`, `$clog2(WINDOW+1)`: width of the match count.

Ports:
- `clk` in 1: rising-edge clock. Single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `din` in 1: serial bit. Connects to `behavioral_model.y`.
- `din_en` in 1: sample qualifier. `din` is consumed only on cycles where `din_en`=1.
- `match` out 1: registered one-cycle pulse per detected pattern.
- `rpt_valid` out 1: a window count is available.
- `rpt_ready` in 1: downstream accepts the count.
- `rpt_count` out CNT_W: number of matches in the completed window.
- `overrun` out 1: sticky. Set when a window count is dropped.
- `clear` in 1: synchronous clear of `overrun`.

## Operation
- Shift register `hist[PAT_W-1:0]`. On each qualified sample: `hist <= {hist[PAT_W-2:0], din}`.
- Detection FSM states:
  - `IDLE`: reset state, no samples taken yet. First qualified sample goes to `FILL`.
  - `FILL`: fewer than `PAT_W` samples since reset. `match` is suppressed. Moves to `RUN` when the `PAT_W`-th sample is taken.
  - `RUN`: the PAT_W-th sample and every later qualified sample compares the new `hist` value to `PATTERN` and pulses `match` on equality (overlapping matches allowed).
- History persists across window boundaries. A pattern that straddles two windows counts in the window holding its final bit.
- Window counters:
  - `samp_cnt` counts qualified samples from 0 to `WINDOW-1`, then wraps.
  - `match_cnt` accumulates matches and saturates at `2^CNT_W - 1`.
- Window end (qualified sample with `samp_cnt == WINDOW-1`):
  - The final count is `match_cnt` plus the current sample's match.
  - If the report slot is empty, or is being drained this cycle (`rpt_valid && rpt_ready`), load `rpt_count` with the final count and set `rpt_valid`.
  - Otherwise drop the count and set `overrun`.
  - In both cases `match_cnt` restarts at 0.
- Handshake: `rpt_valid` stays high and `rpt_count` stays stable until a cycle with `rpt_ready`=1. Transfer occurs on `rpt_valid && rpt_ready`.
- `overrun`: `clear` clears it. If a set and `clear` happen in the same cycle, set wins.
- Reset mid-operation: returns to `IDLE` immediately. Any pending report is lost.

## Timing
- Reset values: `match`=0, `rpt_valid`=0, `rpt_count`=0, `overrun`=0. FSM in `IDLE`; `hist`, `samp_cnt`, `match_cnt` all 0.
- `match` asserts in the cycle after the sampling edge of the completing bit. Latency is 1.
- `rpt_valid` asserts in the cycle after the window's last qualified sample.
- If `rpt_ready` is held high, the report slot drains in one cycle, so back-to-back windows never overrun.
- `din_en`=0 freezes all sampling state. The handshake and `clear` still operate.

## Configuration
Macro `STREAM_MON_RUNLEN_EN`.
- Defined: adds output `max_run` [CNT_W] and a run counter.
  - `max_run` is the longest run of consecutive 1s within the window.
  - It is latched alongside `rpt_count` under the same `rpt_valid`.
  - The run counter resets at each window boundary and after each 0.
  - Runs do not carry across windows.
- Undefined: no `max_run` port and no run logic.

## Structure
- Package `stream_mon_pkg`:
  - `typedef enum logic [1:0] {IDLE, FILL, RUN} det_state_t`.
  - Default `PATTERN` and `WINDOW` constants.
- Sub-module `pattern_matcher`: the shift register, the FSM and the `match` output.
- Top level: window counters, report register, `overrun` logic.

## Test plan
- Reset then stream 1,0,1,1,0,1,1 with `din_en`=1 → `match` pulses after samples 4 and 7 (overlap).
- 16 samples with `rpt_ready`=1, stream 1011 repeated → `rpt_valid` for 1 cycle with `rpt_count`=4.
- `rpt_ready`=0 across two full windows → first count is held stable; `overrun`=1 after the second window end. `clear` → `overrun`=0.
- Window end coinciding with a drain (`rpt_ready` rises on the same cycle) → new count loads, `overrun` stays 0.
- `reset` asserted mid-window with 2 matches counted → all outputs 0 asynchronously. The next 3 samples produce no `match` (`FILL`).
- `STREAM_MON_RUNLEN_EN` build, window containing 0111110 → `max_run`=5 with the report.
